// File: rtl/i2c_slave_byte_ctrl.sv
// rtl/i2c_slave_byte_ctrl.sv - I2C target byte engine: START/STOP decode, address match, RX/TX shifting, SCL stretch
module i2c_slave_byte_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ena_i,
  input  logic [6:0] addr_i,
  input  logic       nack_i,
  input  logic [7:0] tx_dat_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_dat_o,
  output logic       rx_valid_o,
  output logic       sel_o,
  output logic       rw_o,
  output logic       busy_o,
  output logic       rxack_o,
  output logic       stop_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       scl_dir_o,
  output logic       sda_dir_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_LOAD, TX, TX_ACK, WAIT_STOP
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic       scl_q, sda_q;
  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       ack_due, ack_due_nxt;
  logic       nack_q, nack_q_nxt;
  logic [7:0] rx_dat_nxt;
  logic       rx_valid_nxt, sel_nxt, rw_nxt, busy_nxt, rxack_nxt, stop_nxt;
  logic       scl_dir_nxt, sda_dir_nxt;

  // Synchronizer chain plus one history flop; idle bus level is high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign byte_in   = {shreg[6:0], sda_s};

  assign tx_ready_o = ena_i & (state == TX_LOAD);
  assign scl_o      = 1'b0;
  assign sda_o      = 1'b0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      ack_due    <= 1'b0;
      nack_q     <= 1'b0;
      rx_dat_o   <= 8'd0;
      rx_valid_o <= 1'b0;
      sel_o      <= 1'b0;
      rw_o       <= 1'b0;
      busy_o     <= 1'b0;
      rxack_o    <= 1'b0;
      stop_o     <= 1'b0;
      scl_dir_o  <= 1'b0;
      sda_dir_o  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      ack_due    <= ack_due_nxt;
      nack_q     <= nack_q_nxt;
      rx_dat_o   <= rx_dat_nxt;
      rx_valid_o <= rx_valid_nxt;
      sel_o      <= sel_nxt;
      rw_o       <= rw_nxt;
      busy_o     <= busy_nxt;
      rxack_o    <= rxack_nxt;
      stop_o     <= stop_nxt;
      scl_dir_o  <= scl_dir_nxt;
      sda_dir_o  <= sda_dir_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    ack_due_nxt  = ack_due;
    nack_q_nxt   = nack_q;
    rx_dat_nxt   = rx_dat_o;
    rx_valid_nxt = 1'b0;
    sel_nxt      = sel_o;
    rw_nxt       = rw_o;
    busy_nxt     = busy_o;
    rxack_nxt    = rxack_o;
    stop_nxt     = 1'b0;
    scl_dir_nxt  = scl_dir_o;
    sda_dir_nxt  = sda_dir_o;

    if (!ena_i) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = 3'd0;
      ack_due_nxt = 1'b0;
      sel_nxt     = 1'b0;
      rw_nxt      = 1'b0;
      busy_nxt    = 1'b0;
      rxack_nxt   = 1'b0;
      scl_dir_nxt = 1'b0;
      sda_dir_nxt = 1'b0;
    end else if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 3'd0;
      ack_due_nxt = 1'b0;
      sel_nxt     = 1'b0;
      busy_nxt    = 1'b1;
      scl_dir_nxt = 1'b0;
      sda_dir_nxt = 1'b0;
    end else if (stop_det) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = 3'd0;
      ack_due_nxt = 1'b0;
      stop_nxt    = sel_o;
      sel_nxt     = 1'b0;
      busy_nxt    = 1'b0;
      scl_dir_nxt = 1'b0;
      sda_dir_nxt = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shreg_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_in[7:1] == addr_i) begin
                rw_nxt      = byte_in[0];
                ack_due_nxt = 1'b1;
              end else begin
                state_nxt = WAIT_STOP;
              end
            end
          end else if (scl_fall && ack_due) begin
            ack_due_nxt = 1'b0;
            sda_dir_nxt = 1'b1;
            sel_nxt     = 1'b1;
            state_nxt   = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_dir_nxt = 1'b0;
            state_nxt   = rw_o ? TX_LOAD : RX;
          end
        end
        RX: begin
          if (scl_rise) begin
            shreg_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_dat_nxt   = byte_in;
              rx_valid_nxt = 1'b1;
              nack_q_nxt   = nack_i;
              ack_due_nxt  = 1'b1;
            end
          end else if (scl_fall && ack_due) begin
            ack_due_nxt = 1'b0;
            if (nack_q) begin
              state_nxt = WAIT_STOP;
            end else begin
              sda_dir_nxt = 1'b1;
              state_nxt   = RX_ACK;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_dir_nxt = 1'b0;
            state_nxt   = RX;
          end
        end
        TX_LOAD: begin
          // SCL is held low here until the front-end supplies a byte.
          if (tx_valid_i) begin
            shreg_nxt   = tx_dat_i;
            sda_dir_nxt = ~tx_dat_i[7];
            scl_dir_nxt = 1'b0;
            bit_cnt_nxt = 3'd0;
            state_nxt   = TX;
          end else begin
            scl_dir_nxt = 1'b1;
          end
        end
        TX: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_dir_nxt = 1'b0;
              bit_cnt_nxt = 3'd0;
              ack_due_nxt = 1'b0;
              state_nxt   = TX_ACK;
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
              shreg_nxt   = {shreg[6:0], 1'b0};
              sda_dir_nxt = ~shreg[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            rxack_nxt = sda_s;
            if (sda_s) state_nxt = WAIT_STOP;
            else ack_due_nxt = 1'b1;
          end else if (scl_fall && ack_due) begin
            ack_due_nxt = 1'b0;
            state_nxt   = TX_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// tb/tb_i2c_slave_byte_ctrl.sv - bench for i2c_slave_byte_ctrl with an open-drain bus master and transaction model
module tb_i2c_slave_byte_ctrl;
  localparam int Q = 6;
  localparam int BOUND = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena, nack, tx_valid;
  logic [6:0] addr;
  logic [7:0] tx_dat;
  logic       tx_ready_o, rx_valid_o, sel_o, rw_o, busy_o, rxack_o, stop_o;
  logic [7:0] rx_dat_o;
  logic       scl_o, sda_o, scl_dir_o, sda_dir_o;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_line, sda_line;

  assign scl_line = scl_m & ~scl_dir_o;
  assign sda_line = sda_m & ~sda_dir_o;

  i2c_slave_byte_ctrl #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ena_i(ena), .addr_i(addr), .nack_i(nack),
    .tx_dat_i(tx_dat), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
    .rx_dat_o(rx_dat_o), .rx_valid_o(rx_valid_o), .sel_o(sel_o), .rw_o(rw_o),
    .busy_o(busy_o), .rxack_o(rxack_o), .stop_o(stop_o),
    .scl_i(scl_line), .sda_i(sda_line), .scl_o(scl_o), .sda_o(sda_o),
    .scl_dir_o(scl_dir_o), .sda_dir_o(sda_dir_o)
  );

  int errors = 0;
  int checks = 0;

  // Event recorder: only this block writes these; tests work on deltas.
  logic [7:0] rx_seen[$];
  int stretches[$];
  int stop_cnt = 0, sda_drv = 0, scl_drv = 0, run = 0;
  always @(negedge clk) begin
    if (rx_valid_o) rx_seen.push_back(rx_dat_o);
    if (stop_o) stop_cnt <= stop_cnt + 1;
    if (sda_dir_o) sda_drv <= sda_drv + 1;
    if (scl_dir_o) begin
      scl_drv <= scl_drv + 1;
      run <= run + 1;
    end else begin
      if (run > 0) stretches.push_back(run);
      run <= 0;
    end
  end

  logic [7:0] tx_q[$];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int n;
    n = 0;
    while (scl_line !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      checks++; errors++;
      $display("FAIL scl_release_timeout: scl low for %0d clk, required released", n);
    end
  endtask

  task automatic clk_bit(input logic b, output logic r);
    sda_m = b;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_scl_high();
    wait_clk(Q);
    r = sda_line;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic m_start();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic m_rstart();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_scl_high(); wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_scl_high(); wait_clk(Q);
    sda_m = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic m_write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic m_read_byte(input logic mnack, output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, r);
      d = {d[6:0], r};
    end
    clk_bit(mnack, r);
  endtask

  task automatic feed(input int first_delay);
    int n;
    for (int k = 0; k < tx_q.size(); k++) begin
      n = 0;
      while (tx_ready_o !== 1'b1 && n < BOUND) begin
        @(negedge clk);
        n++;
      end
      if (n >= BOUND) begin
        checks++; errors++;
        $display("FAIL tx_ready_timeout: byte %0d never requested after %0d clk", k, n);
        return;
      end
      if (k == 0) wait_clk(first_delay);
      tx_dat = tx_q[k];
      tx_valid = 1'b1;
      wait_clk(1);
      tx_valid = 1'b0;
    end
  endtask

  function automatic logic [14:0] outs();
    return {tx_ready_o, rx_valid_o, sel_o, rw_o, busy_o, rxack_o, stop_o,
            scl_o, sda_o, scl_dir_o, sda_dir_o, 4'h0} | {7'h0, rx_dat_o};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; addr = 7'h50; nack = 1'b0; tx_valid = 1'b0; tx_dat = 8'h00;
    wait_clk(3);
    checks++;
    if (outs() !== 15'h0) $display("FAIL reset_outputs: got %h want 0", outs());
    if (outs() !== 15'h0) errors++;
    rst_n = 1'b1;
    wait_clk(5);
    checks++;
    if (outs() !== 15'h0) begin errors++; $display("FAIL idle_outputs: got %h want 0", outs()); end
  endtask

  task automatic test_write();
    logic ack, a1, a2;
    int rx0, st0;
    addr = 7'h50; nack = 1'b0; rx0 = rx_seen.size(); st0 = stop_cnt;
    m_start();
    m_write_byte({7'h50, 1'b0}, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL write_addr_ack: got %b want 0", ack); end
    checks++;
    if ({sel_o, busy_o, rw_o} !== 3'b110) begin
      errors++; $display("FAIL write_sel_busy_rw: got %b want 110", {sel_o, busy_o, rw_o});
    end
    m_write_byte(8'hA5, a1);
    m_write_byte(8'h3C, a2);
    checks++;
    if ({a1, a2} !== 2'b00) begin errors++; $display("FAIL write_data_acks: got %b want 00", {a1, a2}); end
    m_stop(); wait_clk(2);
    checks++;
    if (rx_seen.size() - rx0 != 2) begin
      errors++; $display("FAIL write_rx_count: got %0d want 2", rx_seen.size() - rx0);
    end else if (rx_seen[rx0] !== 8'hA5 || rx_seen[rx0+1] !== 8'h3C) begin
      errors++; $display("FAIL write_rx_data: got %h %h want a5 3c", rx_seen[rx0], rx_seen[rx0+1]);
    end
    checks++;
    if (stop_cnt - st0 != 1) begin errors++; $display("FAIL write_stop_pulse: got %0d want 1", stop_cnt - st0); end
    checks++;
    if ({sel_o, busy_o, rx_dat_o} !== {2'b00, 8'h3C}) begin
      errors++; $display("FAIL write_after_stop: got sel=%b busy=%b rx=%h want 0 0 3c", sel_o, busy_o, rx_dat_o);
    end
  endtask

  task automatic test_read_stretch();
    logic ack;
    logic [7:0] d0, d1;
    int s0, mx, st0;
    addr = 7'h50; s0 = stretches.size(); st0 = stop_cnt;
    tx_q = '{8'h81, 8'h7E};
    fork
      begin
        m_start();
        m_write_byte({7'h50, 1'b1}, ack);
        m_read_byte(1'b0, d0);
        m_read_byte(1'b1, d1);
      end
      feed(40);
    join
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b want 0", ack); end
    checks++;
    if ({d0, d1} !== 16'h817E) begin errors++; $display("FAIL read_bytes: got %h want 817e", {d0, d1}); end
    mx = 0;
    for (int i = s0; i < stretches.size(); i++) if (stretches[i] > mx) mx = stretches[i];
    checks++;
    if (mx < 38 || mx > 42) begin errors++; $display("FAIL read_stretch_len: got %0d want 38..42", mx); end
    checks++;
    if ({rxack_o, rw_o, sel_o, sda_dir_o, scl_dir_o} !== 5'b11100) begin
      errors++; $display("FAIL read_wait_stop: got %b want 11100", {rxack_o, rw_o, sel_o, sda_dir_o, scl_dir_o});
    end
    m_stop(); wait_clk(2);
    checks++;
    if (stop_cnt - st0 != 1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL read_stop: got pulses=%0d busy=%b want 1 0", stop_cnt - st0, busy_o);
    end
  endtask

  task automatic test_addr_mismatch();
    logic ack, a1;
    int sd0, sc0, st0;
    addr = 7'h50; sd0 = sda_drv; sc0 = scl_drv; st0 = stop_cnt;
    m_start();
    m_write_byte({7'h51, 1'b0}, ack);
    m_write_byte(8'h55, a1);
    checks++;
    if ({ack, a1} !== 2'b11) begin errors++; $display("FAIL mismatch_acks: got %b want 11", {ack, a1}); end
    checks++;
    if ({sel_o, busy_o} !== 2'b01) begin errors++; $display("FAIL mismatch_sel_busy: got %b want 01", {sel_o, busy_o}); end
    m_stop(); wait_clk(2);
    checks++;
    if (sda_drv != sd0 || scl_drv != sc0) begin
      errors++; $display("FAIL mismatch_drive: got sda=%0d scl=%0d cycles want 0 0", sda_drv - sd0, scl_drv - sc0);
    end
    checks++;
    if (busy_o !== 1'b0 || stop_cnt != st0) begin
      errors++; $display("FAIL mismatch_stop: got busy=%b pulses=%0d want 0 0", busy_o, stop_cnt - st0);
    end
  endtask

  task automatic test_nack();
    logic ack, a1, a2;
    int rx0, sd0;
    addr = 7'h50; rx0 = rx_seen.size();
    m_start();
    m_write_byte({7'h50, 1'b0}, ack);
    sd0 = sda_drv; nack = 1'b1;
    m_write_byte(8'h12, a1);
    m_write_byte(8'h34, a2);
    nack = 1'b0;
    checks++;
    if ({ack, a1, a2} !== 3'b011) begin errors++; $display("FAIL nack_acks: got %b want 011", {ack, a1, a2}); end
    checks++;
    if (sda_drv != sd0) begin errors++; $display("FAIL nack_sda_drive: got %0d cycles want 0", sda_drv - sd0); end
    m_stop(); wait_clk(2);
    checks++;
    if (rx_seen.size() - rx0 != 1 || rx_seen[rx_seen.size()-1] !== 8'h12) begin
      errors++; $display("FAIL nack_rx: got count=%0d last=%h want 1 12", rx_seen.size() - rx0, rx_dat_o);
    end
  endtask

  task automatic test_repeated_start();
    logic ack, a1, ack2;
    logic [7:0] d;
    int st0;
    addr = 7'h50; st0 = stop_cnt;
    tx_q = '{8'hC3};
    m_start();
    m_write_byte({7'h50, 1'b0}, ack);
    m_write_byte(8'h5A, a1);
    checks++;
    if ({ack, a1, rw_o, sel_o} !== 4'b0001) begin
      errors++; $display("FAIL rs_first_phase: got %b want 0001", {ack, a1, rw_o, sel_o});
    end
    fork
      begin
        m_rstart();
        m_write_byte({7'h50, 1'b1}, ack2);
        m_read_byte(1'b1, d);
      end
      feed(0);
    join
    checks++;
    if ({ack2, rw_o, sel_o, d} !== {3'b011, 8'hC3}) begin
      errors++; $display("FAIL rs_read_phase: got ack=%b rw=%b sel=%b d=%h want 0 1 1 c3", ack2, rw_o, sel_o, d);
    end
    checks++;
    if (stop_cnt != st0) begin errors++; $display("FAIL rs_early_stop: got %0d pulses want 0", stop_cnt - st0); end
    m_stop(); wait_clk(2);
    checks++;
    if (stop_cnt - st0 != 1) begin errors++; $display("FAIL rs_final_stop: got %0d want 1", stop_cnt - st0); end
  endtask

  task automatic test_abort_and_reset();
    logic ack, r;
    int rx0, st0;
    addr = 7'h50; rx0 = rx_seen.size(); st0 = stop_cnt;
    m_start();
    m_write_byte({7'h50, 1'b0}, ack);
    for (int i = 0; i < 4; i++) clk_bit(i[0], r);
    m_stop(); wait_clk(2);
    checks++;
    if (rx_seen.size() != rx0 || stop_cnt - st0 != 1) begin
      errors++; $display("FAIL abort_rx_stop: got rx=%0d stop=%0d want 0 1", rx_seen.size() - rx0, stop_cnt - st0);
    end
    checks++;
    if ({sel_o, busy_o, sda_dir_o, scl_dir_o, tx_ready_o} !== 5'b0) begin
      errors++; $display("FAIL abort_idle: got %b want 00000", {sel_o, busy_o, sda_dir_o, scl_dir_o, tx_ready_o});
    end
    m_start();
    m_write_byte({7'h50, 1'b1}, ack);
    wait_clk(20);
    checks++;
    if ({ack, scl_dir_o, tx_ready_o} !== 3'b011) begin
      errors++; $display("FAIL stretch_active: got %b want 011", {ack, scl_dir_o, tx_ready_o});
    end
    st0 = stop_cnt;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 15'h0) begin errors++; $display("FAIL async_reset_outputs: got %h want 0", outs()); end
    wait_clk(2);
    rst_n = 1'b1;
    m_stop(); wait_clk(2);
    checks++;
    if (outs() !== 15'h0 || stop_cnt != st0) begin
      errors++; $display("FAIL post_reset_idle: got %h pulses=%0d want 0 0", outs(), stop_cnt - st0);
    end
  endtask

  task automatic test_random_writes();
    logic [6:0] own, tgt;
    logic [7:0] d;
    logic [7:0] exp_rx[$];
    logic ack, exp_ack;
    logic match;
    int n, nack_at, bi, rx0, st0, sd0;
    for (int t = 0; t < 6; t++) begin
      own = 7'($urandom); match = 1'($urandom_range(0, 1)); tgt = own;
      if (!match) begin bi = $urandom_range(0, 6); tgt[bi] = ~tgt[bi]; end
      n = $urandom_range(1, 3); nack_at = $urandom_range(0, n);
      exp_rx.delete(); rx0 = rx_seen.size(); st0 = stop_cnt; sd0 = sda_drv;
      addr = own;
      m_start();
      m_write_byte({tgt, 1'b0}, ack);
      checks++;
      if (ack !== ~match) begin errors++; $display("FAIL rnd_w%0d_addr_ack: got %b want %b", t, ack, ~match); end
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        nack = (k == nack_at);
        m_write_byte(d, ack);
        exp_ack = (match && k < nack_at) ? 1'b0 : 1'b1;
        if (match && k <= nack_at) exp_rx.push_back(d);
        checks++;
        if (ack !== exp_ack) begin errors++; $display("FAIL rnd_w%0d_b%0d_ack: got %b want %b", t, k, ack, exp_ack); end
      end
      nack = 1'b0;
      m_stop(); wait_clk(2);
      checks++;
      if (rx_seen.size() - rx0 != exp_rx.size()) begin
        errors++; $display("FAIL rnd_w%0d_rx_count: got %0d want %0d", t, rx_seen.size() - rx0, exp_rx.size());
      end else begin
        for (int k = 0; k < exp_rx.size(); k++) begin
          checks++;
          if (rx_seen[rx0+k] !== exp_rx[k]) begin
            errors++; $display("FAIL rnd_w%0d_rx%0d: got %h want %h", t, k, rx_seen[rx0+k], exp_rx[k]);
          end
        end
      end
      checks++;
      if (stop_cnt - st0 != int'(match) || (!match && sda_drv != sd0)) begin
        errors++; $display("FAIL rnd_w%0d_stop_drive: got stop=%0d drv=%0d want %0d", t, stop_cnt - st0, sda_drv - sd0, match);
      end
    end
  endtask

  task automatic test_random_reads();
    logic [6:0] own;
    logic [7:0] got[$];
    logic [7:0] d;
    logic ack;
    int n, dly;
    for (int t = 0; t < 3; t++) begin
      own = 7'($urandom); n = $urandom_range(1, 3); dly = $urandom_range(0, 30);
      addr = own; tx_q.delete(); got.delete();
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
      fork
        begin
          m_start();
          m_write_byte({own, 1'b1}, ack);
          for (int k = 0; k < n; k++) begin
            m_read_byte(k == n - 1, d);
            got.push_back(d);
          end
        end
        feed(dly);
      join
      checks++;
      if (ack !== 1'b0 || rxack_o !== 1'b1) begin
        errors++; $display("FAIL rnd_r%0d_acks: got addr_ack=%b rxack=%b want 0 1", t, ack, rxack_o);
      end
      for (int k = 0; k < n; k++) begin
        checks++;
        if (got[k] !== tx_q[k]) begin errors++; $display("FAIL rnd_r%0d_byte%0d: got %h want %h", t, k, got[k], tx_q[k]); end
      end
      m_stop(); wait_clk(2);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read_stretch();
    test_addr_mismatch();
    test_nack();
    test_repeated_start();
    test_abort_and_reset();
    test_random_writes();
    test_random_reads();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
